// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core, with load-use bubble insertion.
// Define ID_EX_LOAD_USE_DETECT_EN to enable the internal load-use detector.
module id_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [12:0]     id_ctrl,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    output logic            ex_valid,
    output logic [12:0]     ex_ctrl,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            hazard_stall
);

    localparam int unsigned MemReadBit = 11;

    logic            valid_q, valid_d;
    logic [12:0]     ctrl_q, ctrl_d;
    logic            data_load;
    logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [2:0]      funct3_q;
    logic            funct7b5_q;

`ifdef ID_EX_LOAD_USE_DETECT_EN
    logic load_use;
    assign load_use = id_valid & valid_q & ctrl_q[MemReadBit] & (rd_q != 5'd0) &
                      ((rd_q == id_rs1) | (rd_q == id_rs2));
    // Flush, external stall and reset all override the detector.
    assign hazard_stall = load_use & ~flush & ~stall_in & ~rst;
`else
    assign hazard_stall = 1'b0;
`endif

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        data_load = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (stall_in) begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
        end else if (hazard_stall) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d   = id_valid;
            ctrl_d    = id_valid ? id_ctrl : 13'd0;
            data_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            // Bubbles leave the data fields untouched; only a real load updates them.
            if (data_load) begin
                pc_q       <= id_pc;
                rs1_data_q <= id_rs1_data;
                rs2_data_q <= id_rs2_data;
                imm_q      <= id_imm;
                rs1_q      <= id_rs1;
                rs2_q      <= id_rs2;
                rd_q       <= id_rd;
                funct3_q   <= id_funct3;
                funct7b5_q <= id_funct7b5;
            end
        end
    end

    assign ex_valid    = valid_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_funct3   = funct3_q;
    assign ex_funct7b5 = funct7b5_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against a behavioural model of the stage.
module tb_id_ex_stage;

    localparam int unsigned XLEN = 32;
`ifdef ID_EX_LOAD_USE_DETECT_EN
    localparam bit HazEn = 1'b1;
`else
    localparam bit HazEn = 1'b0;
`endif

    typedef struct {
        logic            rst, stall, flush, valid;
        logic [12:0]     ctrl;
        logic [XLEN-1:0] pc, rs1d, rs2d, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [2:0]      f3;
        logic            f7;
    } in_t;

    typedef struct {
        logic            valid;
        logic [12:0]     ctrl;
        logic [XLEN-1:0] pc, rs1d, rs2d, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [2:0]      f3;
        logic            f7;
    } ex_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t in;
    ex_t mdl;
    int  checks = 0;
    int  errors = 0;

    logic            ex_valid, ex_funct7b5, hazard_stall;
    logic [12:0]     ex_ctrl;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (in.rst),
        .stall_in    (in.stall),
        .flush       (in.flush),
        .id_valid    (in.valid),
        .id_ctrl     (in.ctrl),
        .id_pc       (in.pc),
        .id_rs1_data (in.rs1d),
        .id_rs2_data (in.rs2d),
        .id_imm      (in.imm),
        .id_rs1      (in.rs1),
        .id_rs2      (in.rs2),
        .id_rd       (in.rd),
        .id_funct3   (in.f3),
        .id_funct7b5 (in.f7),
        .ex_valid    (ex_valid),
        .ex_ctrl     (ex_ctrl),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_funct3   (ex_funct3),
        .ex_funct7b5 (ex_funct7b5),
        .hazard_stall(hazard_stall)
    );

    // Control bundle encodings: {regwrite, memread, memwrite, branch, jump, memtoreg,
    // alusrc1, alusrc2, lui, pcsrc, aluop[2:0]}
    localparam logic [12:0] CtrlAddi = 13'h1020;
    localparam logic [12:0] CtrlAdd  = 13'h1000;
    localparam logic [12:0] CtrlLw   = 13'h18A0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode reads a register that a load in EX is about to write (x0 never counts).
    function automatic bit model_hazard(input ex_t e, input in_t i);
        bit dep;
        dep = e.valid && e.ctrl[11] && (e.rd != 0) && (e.rd == i.rs1 || e.rd == i.rs2);
        return HazEn && i.valid && dep && !i.flush && !i.stall && !i.rst;
    endfunction

    function automatic ex_t model_next(input ex_t e, input in_t i);
        ex_t n;
        n = e;
        if (i.rst) begin
            n = '{valid: 1'b0, ctrl: '0, pc: '0, rs1d: '0, rs2d: '0, imm: '0,
                  rs1: '0, rs2: '0, rd: '0, f3: '0, f7: 1'b0};
        end else if (i.flush || (!i.stall && model_hazard(e, i))) begin
            n.valid = 1'b0;
            n.ctrl  = '0;
        end else if (!i.stall) begin
            n = '{valid: i.valid, ctrl: i.valid ? i.ctrl : 13'd0, pc: i.pc, rs1d: i.rs1d,
                  rs2d: i.rs2d, imm: i.imm, rs1: i.rs1, rs2: i.rs2, rd: i.rd, f3: i.f3,
                  f7: i.f7};
        end
        return n;
    endfunction

    task automatic check_regs();
        chk("ex_valid", 64'(ex_valid), 64'(mdl.valid));
        chk("ex_ctrl", 64'(ex_ctrl), 64'(mdl.ctrl));
        // Data fields are don't-care in a bubble, except straight after reset.
        if (mdl.valid || in.rst) begin
            chk("ex_pc", 64'(ex_pc), 64'(mdl.pc));
            chk("ex_rs1_data", 64'(ex_rs1_data), 64'(mdl.rs1d));
            chk("ex_rs2_data", 64'(ex_rs2_data), 64'(mdl.rs2d));
            chk("ex_imm", 64'(ex_imm), 64'(mdl.imm));
            chk("ex_rs1", 64'(ex_rs1), 64'(mdl.rs1));
            chk("ex_rs2", 64'(ex_rs2), 64'(mdl.rs2));
            chk("ex_rd", 64'(ex_rd), 64'(mdl.rd));
            chk("ex_funct3", 64'(ex_funct3), 64'(mdl.f3));
            chk("ex_funct7b5", 64'(ex_funct7b5), 64'(mdl.f7));
        end
    endtask

    // Called just after a posedge with new inputs applied; returns just after the next posedge.
    task automatic tick();
        ex_t nxt;
        #2;
        chk("hazard_stall", 64'(hazard_stall), 64'(model_hazard(mdl, in)));
        nxt = model_next(mdl, in);
        @(posedge clk);
        #1;
        mdl = nxt;
        check_regs();
    endtask

    task automatic set_instr(input logic [12:0] ctrl, input logic [XLEN-1:0] pc,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [XLEN-1:0] imm);
        in.valid = 1'b1;
        in.ctrl  = ctrl;
        in.pc    = pc;
        in.rs1   = rs1;
        in.rs2   = rs2;
        in.rd    = rd;
        in.imm   = imm;
        in.rs1d  = $urandom;
        in.rs2d  = $urandom;
        in.f3    = 3'($urandom);
        in.f7    = 1'($urandom);
    endtask

    task automatic randomize_id();
        in.valid = ($urandom_range(0, 4) != 0);
        in.ctrl  = 13'($urandom);
        in.ctrl[11] = ($urandom_range(0, 1) == 1);
        in.pc    = $urandom;
        in.rs1d  = $urandom;
        in.rs2d  = $urandom;
        in.imm   = $urandom;
        in.rs1   = 5'($urandom_range(0, 3));
        in.rs2   = 5'($urandom_range(0, 3));
        in.rd    = 5'($urandom_range(0, 3));
        in.f3    = 3'($urandom);
        in.f7    = 1'($urandom);
    endtask

    initial begin
        mdl = '{valid: 1'b0, ctrl: '0, pc: '0, rs1d: '0, rs2d: '0, imm: '0,
                rs1: '0, rs2: '0, rd: '0, f3: '0, f7: 1'b0};
        in.stall = 1'b0;
        in.flush = 1'b0;
        in.rst   = 1'b1;
        randomize_id();
        @(posedge clk);
        #1;

        // Reset for two cycles with random decode values
        for (int k = 0; k < 2; k++) begin
            randomize_id();
            tick();
            chk("reset_valid", 64'(ex_valid), 64'd0);
            chk("reset_pc", 64'(ex_pc), 64'd0);
            chk("reset_ctrl", 64'(ex_ctrl), 64'd0);
        end
        in.rst = 1'b0;
        set_instr(CtrlAddi, 32'h0000_0004, 5'd1, 5'd2, 5'd5, 32'h0000_000A);
        #1;
        chk("post_reset_hazard", 64'(hazard_stall), 64'd0);
        tick();
        chk("addi_pc", 64'(ex_pc), 64'h4);
        chk("addi_ctrl", 64'(ex_ctrl), 64'(CtrlAddi));
        chk("addi_rd", 64'(ex_rd), 64'd5);
        chk("addi_imm", 64'(ex_imm), 64'hA);
        chk("addi_valid", 64'(ex_valid), 64'd1);

        // LW x6 followed by a consumer of x6 through rs2
        set_instr(CtrlLw, 32'h8, 5'd1, 5'd0, 5'd6, 32'h10);
        tick();
        set_instr(CtrlAdd, 32'hC, 5'd1, 5'd6, 5'd7, 32'h0);
        #1;
        chk("lu_hazard", 64'(hazard_stall), 64'(HazEn));
        tick();
        chk("lu_bubble_valid", 64'(ex_valid), 64'(!HazEn));
        chk("lu_bubble_ctrl", 64'(ex_ctrl), HazEn ? 64'd0 : 64'(CtrlAdd));
        #1;
        chk("lu_hazard_fall", 64'(hazard_stall), 64'd0);
        tick();
        chk("lu_reaccept_valid", 64'(ex_valid), 64'd1);
        chk("lu_reaccept_rd", 64'(ex_rd), 64'd7);

        // LW x0 then a reader of x0: never a hazard
        set_instr(CtrlLw, 32'h10, 5'd2, 5'd0, 5'd0, 32'h4);
        tick();
        set_instr(CtrlAdd, 32'h14, 5'd0, 5'd3, 5'd8, 32'h0);
        #1;
        chk("x0_hazard", 64'(hazard_stall), 64'd0);
        tick();
        chk("x0_valid", 64'(ex_valid), 64'd1);
        chk("x0_pc", 64'(ex_pc), 64'h14);

        // Flush with a load-use condition present
        set_instr(CtrlLw, 32'h18, 5'd2, 5'd0, 5'd6, 32'h8);
        tick();
        set_instr(CtrlAdd, 32'h1C, 5'd6, 5'd3, 5'd9, 32'h0);
        in.flush = 1'b1;
        #1;
        chk("flush_hazard", 64'(hazard_stall), 64'd0);
        tick();
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_ctrl", 64'(ex_ctrl), 64'd0);
        in.flush = 1'b0;

        // Hold for three cycles while decode keeps changing
        set_instr(CtrlAddi, 32'h20, 5'd1, 5'd2, 5'd10, 32'h5);
        tick();
        in.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_instr(CtrlAdd, 32'h100 + 32'(k * 4), 5'd3, 5'd4, 5'd11, 32'h0);
            tick();
            chk("stall_pc", 64'(ex_pc), 64'h20);
            chk("stall_rd", 64'(ex_rd), 64'd10);
        end
        in.stall = 1'b0;
        tick();
        chk("release_pc", 64'(ex_pc), 64'h108);
        chk("release_ctrl", 64'(ex_ctrl), 64'(CtrlAdd));

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            in.rst   = ($urandom_range(0, 39) == 0);
            in.flush = ($urandom_range(0, 9) == 0);
            in.stall = ($urandom_range(0, 7) == 0);
            randomize_id();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
